// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the IF-stage PC sequencer and the debug unit
// that decodes its state output.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } pc_state_e;

    // Fixed instruction size; sequential fetch advances the PC by this amount.
    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter used for the RUN/STEP cycle count.
module sat_counter #(
    parameter int NB = 32
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [NB-1:0] o_cnt
);

    logic [NB-1:0] cnt_reg;

    // Clear has priority over increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clr) begin
            cnt_reg <= '0;
        end else if (i_inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + NB'(1);
        end
    end

    assign o_cnt = cnt_reg;

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage PC sequencer: picks the next PC (clear / redirect / sequential)
// and gates the PC register load under debug run/step/halt and hazard stalls.
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int                NB_PC    = 32,
    parameter int                NB_CNT   = 32,
    parameter logic [NB_PC-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic [NB_PC-1:0]  i_pc,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_stop,
    input  logic              i_clr,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [NB_PC-1:0]  i_target,
    input  logic              i_halt,
    output logic [NB_PC-1:0]  o_pc_next,
    output logic              o_pc_en,
    output logic              o_if_flush,
    output logic [1:0]        o_state,
    output logic              o_step_done,
    output logic [NB_CNT-1:0] o_cycle_cnt
);

    pc_state_e state_reg, state_next;
    logic      step_done_reg, step_done_next;

    logic             active;
    logic             adv;
    logic             halt_take;
    logic [NB_PC-1:0] pc_seq;
    logic [NB_PC-1:0] pc_redirect;

    // Only RUN and STEP let the PC move; a redirect overrides a stall, and a
    // halt decoded behind a taken branch is a wrong-path instruction.
    assign active      = (state_reg == ST_RUN) || (state_reg == ST_STEP);
    assign adv         = i_redirect || !i_stall;
    assign halt_take   = i_halt && !i_redirect;
    assign pc_seq      = i_pc + NB_PC'(INSTR_BYTES);
    assign pc_redirect = i_target & ~NB_PC'(INSTR_BYTES - 1);

    // State and step-completion pulse registers.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            step_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            step_done_reg <= step_done_next;
        end
    end

    // Next-state, next-PC mux and PC load/flush control.
    always_comb begin
        state_next     = state_reg;
        step_done_next = 1'b0;
        o_pc_next      = pc_seq;
        o_pc_en        = 1'b0;
        o_if_flush     = 1'b0;

        if (i_redirect) begin
            o_pc_next = pc_redirect;
        end

        if (active) begin
            o_pc_en    = adv && !halt_take;
            o_if_flush = i_redirect;
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (i_start)     state_next = ST_RUN;
                else if (i_step) state_next = ST_STEP;
            end
            ST_RUN: begin
                if (halt_take)   state_next = ST_HALT;
                else if (i_stop) state_next = ST_IDLE;
            end
            ST_STEP: begin
                if (halt_take) begin
                    state_next = ST_HALT;
                end else if (adv) begin
                    state_next     = ST_IDLE;
                    step_done_next = 1'b1;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase

        // Debug clear beats everything, including a pending step completion.
        if (i_clr) begin
            state_next     = ST_IDLE;
            step_done_next = 1'b0;
            o_pc_next      = RESET_PC;
            o_pc_en        = 1'b1;
        end

        // Keep the PC register quiet and pointed at the boot address in reset.
        if (!i_rst_n) begin
            o_pc_next  = RESET_PC;
            o_pc_en    = 1'b0;
            o_if_flush = 1'b0;
        end
    end

    sat_counter #(
        .NB (NB_CNT)
    ) u_cycle_cnt (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .i_inc   (active),
        .o_cnt   (o_cycle_cnt)
    );

    assign o_state     = state_reg;
    assign o_step_done = step_done_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model of the run/step/halt rules.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_pc = '0;
    logic        i_start = 1'b0, i_step = 1'b0, i_stop = 1'b0, i_clr = 1'b0;
    logic        i_stall = 1'b0, i_redirect = 1'b0, i_halt = 1'b0;
    logic [31:0] i_target = '0;
    logic [31:0] o_pc_next;
    logic        o_pc_en, o_if_flush, o_step_done;
    logic [1:0]  o_state;
    logic [31:0] o_cycle_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer #(
        .NB_PC    (32),
        .NB_CNT   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_pc        (i_pc),
        .i_start     (i_start),
        .i_step      (i_step),
        .i_stop      (i_stop),
        .i_clr       (i_clr),
        .i_stall     (i_stall),
        .i_redirect  (i_redirect),
        .i_target    (i_target),
        .i_halt      (i_halt),
        .o_pc_next   (o_pc_next),
        .o_pc_en     (o_pc_en),
        .o_if_flush  (o_if_flush),
        .o_state     (o_state),
        .o_step_done (o_step_done),
        .o_cycle_cnt (o_cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode names; the numeric values are the published o_state encoding.
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
    int     m_mode = M_IDLE;
    longint m_cnt  = 0;
    bit     m_done = 0;
    bit     armed  = 0;

    // Compare current outputs at the falling edge, then advance the model to
    // what must hold after the next rising edge.
    always @(negedge clk) begin
        bit          moving, takes_halt, go;
        logic [31:0] w_pc;
        bit          w_en, w_fl;

        moving     = (m_mode == M_RUN) || (m_mode == M_STEP);
        takes_halt = i_halt && !i_redirect;
        go         = i_redirect || !i_stall;

        if (!i_rst_n || i_clr) w_pc = 32'h0;
        else if (i_redirect)   w_pc = {i_target[31:2], 2'b00};
        else                   w_pc = 32'((64'(i_pc) + 64'd4) % 64'h1_0000_0000);
        w_en = i_rst_n && (i_clr || (moving && go && !takes_halt));
        w_fl = i_rst_n && moving && i_redirect;

        check("pc_next", o_pc_next, w_pc);
        check("pc_en", 32'(o_pc_en), 32'(w_en));
        check("if_flush", 32'(o_if_flush), 32'(w_fl));
        if (armed) begin
            check("state", 32'(o_state), 32'(m_mode));
            check("cycle_cnt", o_cycle_cnt, 32'(m_cnt));
            check("step_done", 32'(o_step_done), 32'(m_done));
        end

        if (!i_rst_n) begin
            m_mode = M_IDLE; m_cnt = 0; m_done = 0; armed = 1;
        end else if (i_clr) begin
            m_mode = M_IDLE; m_cnt = 0; m_done = 0;
        end else begin
            if (moving && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_done = 0;
            case (m_mode)
                M_IDLE: if (i_start) m_mode = M_RUN; else if (i_step) m_mode = M_STEP;
                M_RUN:  if (takes_halt) m_mode = M_HALT; else if (i_stop) m_mode = M_IDLE;
                M_STEP: if (takes_halt) m_mode = M_HALT;
                        else if (go) begin m_mode = M_IDLE; m_done = 1; end
                default: ;
            endcase
        end
    end

    // Apply one cycle of inputs just after the rising edge, then return just
    // after the falling-edge comparison so literal checks see the same cycle.
    task automatic cyc(input bit rst, input bit st, input bit sp, input bit so,
                       input bit cl, input bit sa, input bit rd, input bit hl,
                       input logic [31:0] tg, input logic [31:0] pc);
        @(posedge clk); #1;
        i_rst_n = rst; i_start = st; i_step = sp; i_stop = so; i_clr = cl;
        i_stall = sa; i_redirect = rd; i_halt = hl; i_target = tg; i_pc = pc;
        @(negedge clk); #2;
    endtask

    initial begin
        // Reset
        cyc(0,0,0,0,0,0,0,0,0,32'h10);
        check("rst_pc_en", 32'(o_pc_en), 0);
        check("rst_pc_next", o_pc_next, 32'h0);
        cyc(0,0,0,0,0,0,0,0,0,0);
        // Start free-run
        cyc(1,1,0,0,0,0,0,0,0,0);
        check("lit_idle_state", 32'(o_state), 32'h0);
        check("lit_idle_cnt", o_cycle_cnt, 32'h0);
        cyc(1,0,0,0,0,0,0,0,0,0);
        check("lit_run_state", 32'(o_state), 32'h1);
        check("lit_run_en", 32'(o_pc_en), 1);
        check("lit_run_next", o_pc_next, 32'h4);
        cyc(1,0,0,0,0,0,0,0,0,0);
        cyc(1,0,0,0,0,0,0,0,0,0);
        check("lit_run_cnt", o_cycle_cnt, 32'h2);
        // Stall window with a redirect in the middle
        cyc(1,0,0,0,0,1,0,0,0,32'h8);
        check("lit_stall_en", 32'(o_pc_en), 0);
        cyc(1,0,0,0,0,1,1,0,32'h103,32'h8);
        check("lit_redir_en", 32'(o_pc_en), 1);
        check("lit_redir_next", o_pc_next, 32'h100);
        check("lit_redir_flush", 32'(o_if_flush), 1);
        cyc(1,0,0,0,0,1,0,0,0,32'h100);
        check("lit_stall2_flush", 32'(o_if_flush), 0);
        // Halt killed by redirect, then a real halt
        cyc(1,0,0,0,0,0,1,1,32'h200,32'h100);
        check("lit_halt_redir_en", 32'(o_pc_en), 1);
        cyc(1,0,0,0,0,0,0,1,0,32'h200);
        check("lit_halt_state_run", 32'(o_state), 32'h1);
        check("lit_halt_en", 32'(o_pc_en), 0);
        cyc(1,1,0,0,0,0,0,0,0,32'h200);
        check("lit_halt_state", 32'(o_state), 32'h3);
        cyc(1,0,1,0,0,0,0,0,0,32'h200);
        check("lit_halt_hold", 32'(o_state), 32'h3);
        // Clear out of HALT
        cyc(1,0,0,0,1,0,0,0,0,32'h200);
        check("lit_clr_en", 32'(o_pc_en), 1);
        check("lit_clr_next", o_pc_next, 32'h0);
        cyc(1,0,0,0,0,0,0,0,0,0);
        check("lit_clr_state", 32'(o_state), 32'h0);
        check("lit_clr_cnt", o_cycle_cnt, 32'h0);
        // PC wrap, then stop together with a redirect
        cyc(1,1,0,0,0,0,0,0,0,0);
        cyc(1,0,0,0,0,0,0,0,0,32'hFFFF_FFFC);
        check("lit_wrap", o_pc_next, 32'h0);
        cyc(1,0,0,1,0,0,1,0,32'h40,0);
        check("lit_stop_redir_en", 32'(o_pc_en), 1);
        cyc(1,0,0,0,0,0,0,0,0,32'h40);
        check("lit_stop_state", 32'(o_state), 32'h0);
        // Stalled single step
        cyc(1,0,1,0,0,1,0,0,0,32'h10);
        cyc(1,0,0,0,0,1,0,0,0,32'h10);
        check("lit_step_state", 32'(o_state), 32'h2);
        check("lit_step_en", 32'(o_pc_en), 0);
        cyc(1,0,0,0,0,1,0,0,0,32'h10);
        cyc(1,0,0,0,0,0,0,0,0,32'h10);
        check("lit_step_load", o_pc_next, 32'h14);
        check("lit_step_load_en", 32'(o_pc_en), 1);
        cyc(1,0,0,0,0,0,0,0,0,32'h14);
        check("lit_step_idle", 32'(o_state), 32'h0);
        check("lit_step_done", 32'(o_step_done), 1);
        cyc(1,0,0,0,0,0,0,0,0,32'h14);
        check("lit_step_done_off", 32'(o_step_done), 0);
        // Reset while a step is about to complete
        cyc(1,0,1,0,0,1,0,0,0,32'h20);
        cyc(1,0,0,0,0,1,0,0,0,32'h20);
        cyc(0,0,0,0,0,0,0,0,0,32'h20);
        check("lit_rst_step_en", 32'(o_pc_en), 0);
        cyc(1,0,0,0,0,0,0,0,0,32'h20);
        check("lit_rst_step_state", 32'(o_state), 32'h0);
        check("lit_rst_step_done", 32'(o_step_done), 0);

        // Randomized traffic, checked by the model every cycle
        for (int k = 0; k < 4000; k++) begin
            cyc($urandom_range(0, 199) != 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 79) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 11) == 0,
                $urandom,
                ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller that sequences the CPU core's program counter register: computes the next PC (sequential, branch/jump redirect, or clear to boot address) and generates its load enable under run / single-step / halt control from the debug unit and stall requests from the hazard unit. Sits in the IF stage between the debug unit, the hazard/branch logic, and the PC register. The PC register holds the value; this block decides when and what it loads.

## Interface
- NB_PC, 32, width of PC values
- NB_CNT, 32, width of cycle counter
- RESET_PC, 0, boot address loaded by clear

- clk  in  1  clock
- i_rst_n  in  1  synchronous reset, active low
- i_pc  in  NB_PC  current PC from the PC register
- i_start  in  1  debug: enter free-run
- i_step  in  1  debug: advance exactly one PC
- i_stop  in  1  debug: pause free-run
- i_clr  in  1  debug: load RESET_PC, clear counter, return to IDLE
- i_stall  in  1  hazard unit: hold PC
- i_redirect  in  1  EX: taken branch/jump
- i_target  in  NB_PC  redirect target
- i_halt  in  1  ID: halt instruction decoded
- o_pc_next  out  NB_PC  value for PC register input
- o_pc_en  out  1  PC register load enable
- o_if_flush  out  1  flush IF/ID on accepted redirect
- o_state  out  2  current state
- o_step_done  out  1  one-cycle pulse after a step completes
- o_cycle_cnt  out  NB_CNT  cycles spent in RUN/STEP

## Operation
- States: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALT=2'b11.
- Advance condition adv = i_redirect | ~i_stall; valid only in RUN/STEP.
- o_pc_next: i_clr → RESET_PC; else i_redirect → {i_target[NB_PC-1:2],2'b00}; else i_pc+4, modulo 2^NB_PC (0xFFFFFFFC → 0x0).
- o_pc_en: i_clr in any state → 1; RUN/STEP → adv & ~halt_take; IDLE/HALT → 0.
- halt_take = i_halt & ~i_redirect. A redirect kills the younger halt.
- o_if_flush = i_redirect in RUN/STEP; 0 otherwise.
- IDLE: i_start → RUN; i_step → STEP; both → RUN.
- RUN: halt_take → HALT; else i_stop → IDLE. i_stop and i_redirect together: the redirect load still happens, then IDLE.
- STEP: halt_take → HALT; else adv → IDLE and o_step_done=1 next cycle; else (stalled) remain in STEP.
- HALT: only i_clr exits, to IDLE. i_start and i_step are ignored.
- i_clr has highest priority in every state: next state IDLE, counter to 0, PC loads RESET_PC.
- o_cycle_cnt increments every cycle in RUN or STEP. It saturates at all-ones and holds in IDLE/HALT.

## Timing
- State, o_step_done and o_cycle_cnt are registered. o_pc_next, o_pc_en and o_if_flush are combinational from state and inputs; the PC register captures them on the same edge the state updates.
- Reset (i_rst_n=0 at edge): state IDLE, o_cycle_cnt=0, o_step_done=0. While i_rst_n=0, o_pc_en=0, o_if_flush=0, and o_pc_next=RESET_PC. Reset mid-RUN/STEP discards any pending step completion.
- Step latency: an unstalled step goes i_step → STEP (1 edge) → PC load and IDLE (1 edge) → o_step_done high for one cycle.
- Debug inputs are level-sampled each cycle. The debug unit pulses them for one cycle.

## Structure
- Shared package cpu_ctrl_pkg holds the state encodings (ST_IDLE, ST_RUN, ST_STEP, ST_HALT) and INSTR_BYTES=4. The debug unit decodes o_state from the same package.
- One sub-module, sat_counter (parameter NB, ports clk, i_rst_n, i_clr, i_inc, o_cnt), implements o_cycle_cnt.
- The next-PC mux and the FSM stay in the top module.

## Test plan
- Reset, then i_start with i_pc=0x0 and no stall → o_pc_en=1 and o_pc_next=0x4 each cycle; o_state=01; o_cycle_cnt counts 1, 2, 3….
- RUN with i_stall=1 for 3 cycles and i_redirect=1 (i_target=0x103) in the second of them → o_pc_en=1 only in the redirect cycle, o_pc_next=0x100, o_if_flush=1 for that one cycle.
- IDLE then i_step, with i_stall held 2 cycles → state stays STEP, o_pc_en=0. When the stall drops, one load of i_pc+4, state → IDLE, and o_step_done pulses once.
- RUN with i_halt=1 → state HALT, o_pc_en=0, i_start ignored. With i_halt=1 and i_redirect=1 together, the redirect loads and the state stays RUN.
- HALT then i_clr → o_pc_next=RESET_PC, o_pc_en=1, next state IDLE, o_cycle_cnt=0. With i_pc=0xFFFFFFFC in RUN, o_pc_next=0x0.
- Drop i_rst_n for one cycle during STEP → state IDLE, o_step_done stays 0, o_pc_en=0 during reset.
